// File: rtl/tone_voice_scheduler.sv
// Time-multiplexed tone voice scheduler: one shared phase adder serves NUM_VOICES
// voices round-robin, and the per-round sum of the voices' top phase bytes is emitted as a sample.
module tone_voice_scheduler #(
    parameter int NUM_VOICES = 4,
    parameter int SLOT_W     = 2,
    parameter int OUT_W      = 10
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic              wr_en,
    input  logic [SLOT_W-1:0] wr_voice,
    input  logic [15:0]       wr_freq,
    input  logic              wr_gate,
    input  logic              wr_phase_clr,
    output logic [SLOT_W-1:0] slot,
    output logic [OUT_W-1:0]  sample_out,
    output logic              sample_valid
);

    localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_VOICES - 1);

    logic [15:0]           freq  [NUM_VOICES];
    logic [NUM_VOICES-1:0] gate;
    logic [23:0]           phase [NUM_VOICES];
    logic [OUT_W-1:0]      mix_acc;

    logic [15:0]      cur_freq;
    logic [3:0]       shamt;
    logic [23:0]      incr;
    logic [23:0]      phase_next;
    logic [7:0]       term;
    logic [OUT_W-1:0] term_ext;
    logic [OUT_W-1:0] mix_sum;

    // Shared datapath: everything below is computed for the voice in the current slot only.
    always_comb begin
        cur_freq   = freq[slot];
        shamt      = (cur_freq[3:0] > 4'd12) ? 4'd12 : cur_freq[3:0];
        incr       = {12'd0, cur_freq[15:4]} << shamt;
        phase_next = gate[slot] ? (phase[slot] + incr) : 24'd0;
        term       = phase_next[23:16];
        term_ext   = {{(OUT_W - 8){1'b0}}, term};
        mix_sum    = mix_acc + term_ext;
    end

    // The datapath reads the registered values, so a write landing in the voice's own slot
    // only takes effect on its next visit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                freq[v] <= 16'd0;
            end
            gate <= '0;
        end else if (wr_en) begin
            freq[wr_voice] <= wr_freq;
            gate[wr_voice] <= wr_gate;
        end
    end

    // A phase clear from the write port beats the scheduler's own update of that voice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                phase[v] <= 24'd0;
            end
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (wr_en && wr_phase_clr && (wr_voice == SLOT_W'(v))) begin
                    phase[v] <= 24'd0;
                end else if (run && (slot == SLOT_W'(v))) begin
                    phase[v] <= phase_next;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot <= '0;
        end else if (run) begin
            slot <= (slot == LAST_SLOT) ? '0 : slot + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mix_acc      <= '0;
            sample_out   <= '0;
            sample_valid <= 1'b0;
        end else if (run) begin
            if (slot == LAST_SLOT) begin
                sample_out   <= mix_sum;
                mix_acc      <= '0;
                sample_valid <= 1'b1;
            end else begin
                mix_acc      <= mix_sum;
                sample_valid <= 1'b0;
            end
        end else begin
            sample_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_tone_voice_scheduler.sv
// Randomized bench for tone_voice_scheduler against an arithmetic per-voice model,
// plus directed frequency, mix and reset cases.
module tb_tone_voice_scheduler;

    localparam int NV     = 4;
    localparam int SLOT_W = 2;
    localparam int OUT_W  = 10;

    logic              clk;
    logic              rst_n;
    logic              run;
    logic              wr_en;
    logic [SLOT_W-1:0] wr_voice;
    logic [15:0]       wr_freq;
    logic              wr_gate;
    logic              wr_phase_clr;
    logic [SLOT_W-1:0] slot;
    logic [OUT_W-1:0]  sample_out;
    logic              sample_valid;

    int checks = 0;
    int errors = 0;

    int m_freq  [NV];
    int m_gate  [NV];
    int m_phase [NV];
    int m_slot;
    int m_mix;
    int m_sample;
    int m_valid;

    tone_voice_scheduler #(.NUM_VOICES(NV), .SLOT_W(SLOT_W), .OUT_W(OUT_W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .run          (run),
        .wr_en        (wr_en),
        .wr_voice     (wr_voice),
        .wr_freq      (wr_freq),
        .wr_gate      (wr_gate),
        .wr_phase_clr (wr_phase_clr),
        .slot         (slot),
        .sample_out   (sample_out),
        .sample_valid (sample_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic int voice_incr(input int f);
        int e;
        e = f & 15;
        if (e > 12) e = 12;
        return ((f >> 4) & 12'hFFF) * (1 << e);
    endfunction

    function automatic void model_reset();
        for (int v = 0; v < NV; v++) begin
            m_freq[v] = 0; m_gate[v] = 0; m_phase[v] = 0;
        end
        m_slot = 0; m_mix = 0; m_sample = 0; m_valid = 0;
    endfunction

    // One clock of the reference: the visited voice steps with old settings, then writes land.
    function automatic void model_step(input int r, input int we, input int wv,
                                       input int wf, input int wg, input int wc);
        int t;
        m_valid = 0;
        if (r != 0) begin
            if (m_gate[m_slot] != 0) begin
                m_phase[m_slot] = (m_phase[m_slot] + voice_incr(m_freq[m_slot])) % (1 << 24);
                t = m_phase[m_slot] / 65536;
            end else begin
                m_phase[m_slot] = 0;
                t = 0;
            end
            if (m_slot == NV - 1) begin
                m_sample = m_mix + t;
                m_mix    = 0;
                m_valid  = 1;
            end else begin
                m_mix = m_mix + t;
            end
            m_slot = (m_slot + 1) % NV;
        end
        if (we != 0) begin
            m_freq[wv] = wf;
            m_gate[wv] = wg;
            if (wc != 0) m_phase[wv] = 0;
        end
    endfunction

    task automatic cycle(input int r, input int we, input int wv,
                         input int wf, input int wg, input int wc);
        run          = r[0];
        wr_en        = we[0];
        wr_voice     = wv[SLOT_W-1:0];
        wr_freq      = wf[15:0];
        wr_gate      = wg[0];
        wr_phase_clr = wc[0];
        @(posedge clk);
        model_step(r, we, wv, wf, wg, wc);
        #1;
        chk("slot", int'(slot), m_slot);
        chk("sample_valid", int'(sample_valid), m_valid);
        chk("sample_out", int'(sample_out), m_sample);
    endtask

    task automatic do_reset();
        run = 0; wr_en = 0; wr_voice = 0; wr_freq = 0; wr_gate = 0; wr_phase_clr = 0;
        rst_n = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("reset_slot", int'(slot), 0);
        chk("reset_valid", int'(sample_valid), 0);
        chk("reset_sample", int'(sample_out), 0);
        rst_n = 1'b1;
    endtask

    int valid_seen;
    int last_sample;

    initial begin
        do_reset();

        // Idle: no voices gated, slot walks 0..3 and every fourth cycle pulses a zero sample.
        valid_seen = 0;
        for (int i = 0; i < 12; i++) begin
            cycle(1, 0, 0, 0, 0, 0);
            if (sample_valid) valid_seen++;
        end
        chk("idle_valid_count", valid_seen, 3);

        // Single voice at incr 0x010000: samples count 1,2,3... and wrap after 256.
        do_reset();
        cycle(0, 1, 0, 16'h1008, 1, 0);
        repeat (4) cycle(1, 0, 0, 0, 0, 0);
        chk("single_first", int'(sample_out), 1);
        repeat (4) cycle(1, 0, 0, 0, 0, 0);
        chk("single_second", int'(sample_out), 2);
        repeat (254 * 4) cycle(1, 0, 0, 0, 0, 0);
        chk("single_wrap", int'(sample_out), 0);

        // Saturating exponent: 0x001F behaves as 1<<12, so 16 visits reach term 1.
        do_reset();
        cycle(0, 1, 2, 16'h001F, 1, 0);
        repeat (15 * 4) cycle(1, 0, 0, 0, 0, 0);
        chk("sat_15_visits", int'(sample_out), 0);
        repeat (4) cycle(1, 0, 0, 0, 0, 0);
        chk("sat_16_visits", int'(sample_out), 1);

        // Two-voice mix: 0x01 + 0x20 per round.
        do_reset();
        cycle(0, 1, 0, 16'h1008, 1, 0);
        cycle(0, 1, 1, 16'h200C, 1, 0);
        repeat (4) cycle(1, 0, 0, 0, 0, 0);
        chk("mix_round1", int'(sample_out), 'h21);
        repeat (4) cycle(1, 0, 0, 0, 0, 0);
        chk("mix_round2", int'(sample_out), 'h42);

        // All voices at max increment: every term is 0xFF on the first visit.
        do_reset();
        for (int v = 0; v < NV; v++) cycle(0, 1, v, 16'hFFFC, 1, 0);
        repeat (4) cycle(1, 0, 0, 0, 0, 0);
        chk("full_scale", int'(sample_out), 'h3FC);

        // Randomized traffic: writes (often into the live slot), phase clears, freezes.
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            int r, we, wv, wf, wg, wc;
            r  = ($urandom_range(0, 9) < 8) ? 1 : 0;
            we = ($urandom_range(0, 3) == 0) ? 1 : 0;
            wv = ($urandom_range(0, 1) == 0) ? m_slot : $urandom_range(0, NV - 1);
            case ($urandom_range(0, 3))
                0: wf = $urandom_range(0, 16'hFFFF);
                1: wf = ($urandom_range(1, 16'hFFF) << 4) | $urandom_range(12, 15);
                2: wf = ($urandom_range(1, 16'hFFF) << 4) | $urandom_range(0, 8);
                default: wf = 16'h1008;
            endcase
            wg = ($urandom_range(0, 4) != 0) ? 1 : 0;
            wc = ($urandom_range(0, 5) == 0) ? 1 : 0;
            cycle(r, we, wv, wf, wg, wc);
        end

        // Freeze mid-round for 10 cycles at slot 2, then resume.
        while (m_slot != 2) cycle(1, 0, 0, 0, 0, 0);
        last_sample = m_sample;
        repeat (10) cycle(0, 0, 0, 0, 0, 0);
        chk("freeze_slot", int'(slot), 2);
        chk("freeze_sample", int'(sample_out), last_sample);
        repeat (8) cycle(1, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-round clears outputs without a clock edge.
        cycle(1, 0, 0, 0, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_slot", int'(slot), 0);
        chk("async_sample", int'(sample_out), 0);
        chk("async_valid", int'(sample_valid), 0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (8) cycle(1, 0, 0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
